// File: rtl/sccb_init_pkg.sv
// Shared types and constants for the SCCB register-init sequencer.
// Optional readback build: define SCCB_READBACK_EN.
package sccb_init_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PWR_OFF,
      S_PWR_ON,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACK,
      S_DELAY,
      S_DONE,
      S_FAIL,
      S_RD_ISSUE,
      S_RD_WAIT
   } state_t;

   localparam logic [15:0] END_MARK = 16'hFFFF;
   localparam logic [15:0] DLY_MARK = 16'hFFFE;

   // Table entry layout: {reg_addr[15:0], data[7:0]}
   localparam int unsigned ADDR_HI = 23;
   localparam int unsigned ADDR_LO = 8;
   localparam int unsigned DATA_HI = 7;
   localparam int unsigned DATA_LO = 0;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sccb_init_timer.sv
// Loadable down-counter with a zero flag; shared by the power, delay and
// response-timeout waits of the init sequencer.
module sccb_init_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero_c
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks a register-init ROM and issues one SCCB write per entry, with camera
// power sequencing and in-table delays. Define SCCB_READBACK_EN to verify each write.
module sccb_init_sequencer
   import sccb_init_pkg::*;
#(
   parameter int unsigned ROM_AW         = 8,
   parameter int unsigned PWR_CYCLES     = 1000000,
   parameter int unsigned MS_CYCLES      = 100000,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned MAX_RETRY      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              sccb_req,
   output logic              sccb_rw,
   output logic [15:0]       sccb_reg_addr,
   output logic [7:0]        sccb_wdata,
   input  logic              sccb_ack,
   input  logic              sccb_nack,
   input  logic [7:0]        sccb_rdata,
   output logic              cam_gpio,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ROM_AW-1:0] err_index
);

   localparam int unsigned DLY_W   = $clog2(255 * MS_CYCLES + 1);
   localparam int unsigned PWR_W   = max_u(1, $clog2(PWR_CYCLES));
   localparam int unsigned TO_W    = max_u(1, $clog2(TIMEOUT_CYCLES));
   localparam int unsigned TMR_W   = max_u(max_u(DLY_W, PWR_W), TO_W);
   localparam int unsigned RETRY_W = max_u(1, $clog2(MAX_RETRY + 1));

   state_t              state_q, state_d;
   logic [ROM_AW-1:0]   rom_addr_d, err_index_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [15:0]         reg_addr_d;
   logic [7:0]          wdata_d;
   logic                done_d, error_d, advance;
   logic [15:0]         entry_addr;
   logic [7:0]          entry_data;
   logic                tmr_load, tmr_zero_c;
   logic [TMR_W-1:0]    tmr_val, dly_val;

   assign entry_addr = rom_data[ADDR_HI:ADDR_LO];
   assign entry_data = rom_data[DATA_HI:DATA_LO];
   assign dly_val    = TMR_W'(entry_data) * TMR_W'(MS_CYCLES) - TMR_W'(1);

   // Next state, table walk, retry and sticky status
   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr;
      retry_d     = retry_q;
      reg_addr_d  = sccb_reg_addr;
      wdata_d     = sccb_wdata;
      done_d      = done;
      error_d     = error;
      err_index_d = err_index;
      advance     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_d    = S_PWR_OFF;
               done_d     = 1'b0;
               error_d    = 1'b0;
               retry_d    = '0;
               rom_addr_d = '0;
            end
         end
         S_PWR_OFF: if (tmr_zero_c) state_d = S_PWR_ON;
         S_PWR_ON:  if (tmr_zero_c) state_d = S_FETCH;
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            if (entry_addr == END_MARK) begin
               state_d = S_DONE;
            end else if (entry_addr == DLY_MARK) begin
               if (entry_data == 8'h00) advance = 1'b1;
               else                     state_d = S_DELAY;
            end else begin
               reg_addr_d = entry_addr;
               wdata_d    = entry_data;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT_ACK;
         // A simultaneous ack+nack is handled as a nack
         S_WAIT_ACK: begin
            if (sccb_nack) begin
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_FAIL;
               end
            end else if (sccb_ack) begin
`ifdef SCCB_READBACK_EN
               retry_d = '0;
               state_d = S_RD_ISSUE;
`else
               advance = 1'b1;
`endif
            end else if (tmr_zero_c) begin
               state_d = S_FAIL;
            end
         end
         S_DELAY: if (tmr_zero_c) advance = 1'b1;
`ifdef SCCB_READBACK_EN
         S_RD_ISSUE: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (sccb_nack) begin
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = S_RD_ISSUE;
               end else begin
                  state_d = S_FAIL;
               end
            end else if (sccb_ack) begin
               if (sccb_rdata != sccb_wdata) state_d = S_FAIL;
               else                          advance = 1'b1;
            end else if (tmr_zero_c) begin
               state_d = S_FAIL;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Move to the next entry; the last table slot ends the sequence instead of wrapping
      if (advance) begin
         retry_d = '0;
         if (&rom_addr) begin
            state_d = S_DONE;
         end else begin
            state_d    = S_FETCH;
            rom_addr_d = rom_addr + ROM_AW'(1);
         end
      end
      if (state_d == S_DONE && state_q != S_DONE) done_d = 1'b1;
      if (state_d == S_FAIL && state_q != S_FAIL) begin
         error_d     = 1'b1;
         err_index_d = rom_addr;
      end
   end

   // Timer reloads on every state change with the wait that state needs
   always_comb begin
      tmr_load = (state_d != state_q);
      tmr_val  = '0;
      case (state_d)
         S_PWR_OFF, S_PWR_ON:   tmr_val = TMR_W'(PWR_CYCLES - 1);
         S_WAIT_ACK, S_RD_WAIT: tmr_val = TMR_W'(TIMEOUT_CYCLES - 1);
         S_DELAY:               tmr_val = dly_val;
         default:               tmr_val = '0;
      endcase
   end

   sccb_init_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero_c   (tmr_zero_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         rom_addr      <= '0;
         retry_q       <= '0;
         sccb_req      <= 1'b0;
         sccb_reg_addr <= '0;
         sccb_wdata    <= '0;
         cam_gpio      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_index     <= '0;
      end else begin
         state_q       <= state_d;
         rom_addr      <= rom_addr_d;
         retry_q       <= retry_d;
         sccb_req      <= (state_d == S_WAIT_ACK) || (state_d == S_RD_WAIT);
         sccb_reg_addr <= reg_addr_d;
         sccb_wdata    <= wdata_d;
         cam_gpio      <= !(state_d inside {S_IDLE, S_PWR_OFF});
         busy          <= !(state_d inside {S_IDLE, S_DONE, S_FAIL});
         done          <= done_d;
         error         <= error_d;
         err_index     <= err_index_d;
      end
   end

`ifdef SCCB_READBACK_EN
   always_ff @(posedge clk) begin
      if (rst) sccb_rw <= 1'b0;
      else     sccb_rw <= (state_d == S_RD_ISSUE) || (state_d == S_RD_WAIT);
   end
`else
   logic unused_rdata;
   assign sccb_rw      = 1'b0;
   assign unused_rdata = ^sccb_rdata;
`endif

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Randomized and directed bench for sccb_init_sequencer: behavioural ROM,
// scripted SCCB slave and a table-walking reference model.
module tb_sccb_init_sequencer;

   localparam int unsigned ROM_AW = 3;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned PWR    = 10;
   localparam int unsigned MS     = 4;
   localparam int unsigned TMO    = 20;
   localparam int unsigned MAXR   = 2;

   logic              clk = 1'b0;
   logic              rst, start;
   logic [ROM_AW-1:0] rom_addr, err_index;
   logic [23:0]       rom_data;
   logic              sccb_req, sccb_rw, sccb_ack, sccb_nack;
   logic [15:0]       sccb_reg_addr;
   logic [7:0]        sccb_wdata, sccb_rdata;
   logic              cam_gpio, busy, done, error;

   always #5 clk = ~clk;

   sccb_init_sequencer #(
      .ROM_AW(ROM_AW), .PWR_CYCLES(PWR), .MS_CYCLES(MS),
      .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .sccb_req(sccb_req), .sccb_rw(sccb_rw), .sccb_reg_addr(sccb_reg_addr),
      .sccb_wdata(sccb_wdata), .sccb_ack(sccb_ack), .sccb_nack(sccb_nack),
      .sccb_rdata(sccb_rdata), .cam_gpio(cam_gpio), .busy(busy), .done(done),
      .error(error), .err_index(err_index)
   );

   typedef struct packed {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
   } xact_t;

   logic [23:0] rom [DEPTH];
   int          cyc = 0;
   int          tests = 0, fails = 0;
   int          resp_q[$];      // 0 ack, 1 nack, 2 silent, 3 ack+nack
   int          slave_rp;
   bit          corrupt = 1'b0;
   xact_t       obs_q[$], exp_q[$];
   int          obs_cyc[$], ack_cyc[$];
   bit          exp_done, exp_err;
   int          exp_idx;
   int          gpio_rise, err_rise, start_cyc;
   logic        req_at_err;
   logic [7:0]  last_wdata;

   always @(posedge clk) rom_data <= rom[rom_addr];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic xact_t cur_x();
      return xact_t'({sccb_rw, sccb_reg_addr, sccb_rw ? 8'h00 : sccb_wdata});
   endfunction

   // Reference: walk the table entry by entry, consuming scripted responses
   task automatic run_model();
      int          idx = 0, retries = 0, rp = 0, r;
      bit          rd;
      logic [15:0] a;
      logic [7:0]  d;
      exp_q.delete();
      exp_done = 1'b0; exp_err = 1'b0; exp_idx = 0;
      while (!exp_done && !exp_err) begin
         if (idx >= int'(DEPTH)) begin
            exp_done = 1'b1;
            break;
         end
         a = rom[idx][23:8];
         d = rom[idx][7:0];
         if (a == 16'hFFFF) exp_done = 1'b1;
         else if (a == 16'hFFFE) idx++;
         else begin
            rd = 1'b0;
            forever begin
               exp_q.push_back(xact_t'({rd, a, rd ? 8'h00 : d}));
               r = (rp < resp_q.size()) ? resp_q[rp] : 0;
               rp++;
               if (r == 2) begin exp_err = 1'b1; break; end
               if (r != 0) begin
                  if (retries < int'(MAXR)) retries++;
                  else begin exp_err = 1'b1; break; end
               end else begin
                  retries = 0;
`ifdef SCCB_READBACK_EN
                  if (!rd) begin rd = 1'b1; continue; end
                  if (corrupt) begin exp_err = 1'b1; break; end
`endif
                  idx++;
                  break;
               end
            end
            if (exp_err) exp_idx = idx;
         end
      end
   endtask

   // Scripted SCCB slave
   initial begin
      xact_t x;
      int    r, lat, n;
      bit    stable;
      sccb_ack = 1'b0; sccb_nack = 1'b0; sccb_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (sccb_req === 1'b1) begin
            x = cur_x();
            obs_q.push_back(x);
            obs_cyc.push_back(cyc);
            if (!sccb_rw) last_wdata = sccb_wdata;
            r = (slave_rp < resp_q.size()) ? resp_q[slave_rp] : 0;
            slave_rp++;
            if (r == 2) begin
               ack_cyc.push_back(-1);
               n = 0;
               while (sccb_req === 1'b1 && n < 200) begin @(negedge clk); n++; end
            end else begin
               lat = int'($urandom_range(0, 3));
               stable = 1'b1;
               repeat (lat) begin
                  @(negedge clk);
                  if (cur_x() != x || sccb_req !== 1'b1) stable = 1'b0;
               end
               sccb_ack  = (r == 0 || r == 3);
               sccb_nack = (r == 1 || r == 3);
               if (sccb_rw) sccb_rdata = last_wdata + (corrupt ? 8'd1 : 8'd0);
               ack_cyc.push_back(cyc);
               @(negedge clk);
               sccb_ack = 1'b0; sccb_nack = 1'b0;
               check("req_drop", 32'(sccb_req), 0);
               check("req_stable", 32'(stable), 1);
            end
         end
      end
   end

   // Edge monitor for cam_gpio and error
   initial begin
      logic pg, pe;
      pg = 1'b0; pe = 1'b0;
      forever begin
         @(negedge clk);
         if (cam_gpio === 1'b1 && !pg) gpio_rise = cyc;
         if (error === 1'b1 && !pe) begin err_rise = cyc; req_at_err = sccb_req; end
         pg = (cam_gpio === 1'b1);
         pe = (error === 1'b1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic load_tbl(input logic [23:0] t[$]);
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = (i < t.size()) ? t[i] : 24'hFFFF00;
   endtask

   task automatic pulse_raw();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      start_cyc = cyc; gpio_rise = -1; err_rise = -1;
   endtask

   task automatic run_seq(input string tag, input bit restart_busy);
      int n;
      run_model();
      obs_q.delete(); obs_cyc.delete(); ack_cyc.delete(); slave_rp = 0;
      pulse_start();
      if (restart_busy) begin repeat (3) @(negedge clk); pulse_raw(); end
      n = 0;
      while (busy === 1'b1 && n < 4000) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check({tag, "_idle"}, 32'(busy), 0);
      check({tag, "_pwr_low"}, 32'(gpio_rise - start_cyc), PWR);
      check({tag, "_nreq"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check({tag, "_xact"}, 32'(obs_q[i]), 32'(exp_q[i]));
      check({tag, "_done"}, 32'(done), 32'(exp_done));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      if (exp_err) check({tag, "_err_index"}, 32'(err_index), 32'(exp_idx));
      check({tag, "_req_low"}, 32'(sccb_req), 0);
      check({tag, "_gpio_on"}, 32'(cam_gpio), 1);
   endtask

   initial begin
      logic [23:0] spec_tbl[$], t[$];
      int          n, j, c3;
      logic [15:0] a;
      spec_tbl = '{24'h300882, 24'hFFFE02, 24'h310311, 24'hFFFF00};
      rst = 1'b1; start = 1'b0;
      load_tbl(spec_tbl);
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", 32'(sccb_req), 0);
      check("rst_gpio", 32'(cam_gpio), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_rom_addr", 32'(rom_addr), 0);
      check("rst_err_index", 32'(err_index), 0);
      check("rst_rw", 32'(sccb_rw), 0);
      @(negedge clk) rst = 1'b0;

      // Reference table, all acks, with a start pulse while busy
      resp_q = '{};
      run_seq("spec", 1'b1);
      if (obs_q.size() > 0) check("pwr_on_wait", 32'(obs_cyc[0] - gpio_rise >= int'(PWR)), 1);
      j = -1;
      foreach (obs_q[i]) if (j < 0 && obs_q[i].addr == 16'h3103) j = i;
      check("second_write_seen", 32'(j > 0), 1);
      if (j > 0) check("dly_gap", 32'(obs_cyc[j] - ack_cyc[j-1] >= 2 * int'(MS)), 1);

      // Two NACKs then ACK on 3103
`ifdef SCCB_READBACK_EN
      resp_q = '{0, 0, 1, 1, 0, 0};
`else
      resp_q = '{0, 1, 1, 0};
`endif
      run_seq("nack2", 1'b0);
      c3 = 0;
      foreach (obs_q[i]) if (obs_q[i].addr == 16'h3103 && !obs_q[i].rw) c3++;
      check("nack2_writes_3103", 32'(c3), 3);
      check("nack2_done_const", 32'(done), 1);

      // Three NACKs in a row on 3103
`ifdef SCCB_READBACK_EN
      resp_q = '{0, 0, 1, 1, 1};
`else
      resp_q = '{0, 1, 1, 1};
`endif
      run_seq("nack3", 1'b0);
      check("nack3_error_const", 32'(error), 1);
      check("nack3_idx_const", 32'(err_index), 2);

      // Silent slave: timeout
      resp_q = '{2};
      run_seq("silent", 1'b0);
      if (obs_q.size() > 0) check("tmo_latency", 32'(err_rise - obs_cyc[0]), TMO);
      check("tmo_req_at_err", 32'(req_at_err), 0);

      // No end marker: last slot ends the sequence
      t = '{};
      for (int i = 0; i < int'(DEPTH); i++) t.push_back({16'h1000 + 16'(i), 8'(i * 17)});
      load_tbl(t);
      resp_q = '{};
      run_seq("wrap", 1'b0);
      check("wrap_rom_addr", 32'(rom_addr), DEPTH - 1);

      // Reset while waiting for a response
      load_tbl(spec_tbl);
      resp_q = '{2};
      obs_q.delete(); obs_cyc.delete(); ack_cyc.delete(); slave_rp = 0;
      pulse_start();
      n = 0;
      while (sccb_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("rst_mid_reached", 32'(sccb_req), 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_req", 32'(sccb_req), 0);
      check("rst_mid_gpio", 32'(cam_gpio), 0);
      check("rst_mid_busy", 32'(busy), 0);
      @(negedge clk) rst = 1'b0;

      // Randomized tables and response scripts
      for (int k = 0; k < 15; k++) begin
         t = '{};
         for (int i = 0; i < int'(DEPTH); i++) begin
            if ($urandom_range(0, 9) < 2) t.push_back({16'hFFFE, 8'($urandom_range(0, 3))});
            else begin
               a = 16'($urandom);
               if (a >= 16'hFFFE) a = 16'h1234;
               t.push_back({a, 8'($urandom)});
            end
         end
         if ($urandom_range(0, 2) != 0) t[$urandom_range(0, DEPTH - 1)] = 24'hFFFF00;
         load_tbl(t);
         resp_q = '{};
         for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 99));
            resp_q.push_back(n < 70 ? 0 : n < 85 ? 1 : n < 95 ? 3 : 2);
         end
         run_seq("rand", 1'b0);
      end

`ifdef SCCB_READBACK_EN
      load_tbl('{24'h300882, 24'hFFFF00});
      resp_q = '{};
      corrupt = 1'b1;
      run_seq("rb_bad", 1'b0);
      check("rb_bad_error", 32'(error), 1);
      check("rb_bad_idx", 32'(err_index), 0);
      corrupt = 1'b0;
      run_seq("rb_good", 1'b0);
      check("rb_good_done", 32'(done), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
